// File: rtl/alu_issue_stage.sv
// ALU issue stage: register file read with write-back bypass, operand
// selection and a single output register slice feeding the ALU.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. Upstream: in_valid may not depend on in_ready; in_ready is
// (!out_valid | out_ready), so an empty or draining slot takes a new
// instruction. Downstream: once out_valid is high, A/B/ALU_Control/out_rd stay
// stable until the edge where out_ready is sampled high.
module alu_issue_stage #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic [1:0]      in_op,
  input  logic            in_use_imm,
  input  logic [XLEN-1:0] in_imm,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [3:0]      ALU_Control,
  output logic [4:0]      out_rd,
  output logic            out_valid,
  input  logic            out_ready,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [15:0]     issue_count
);

  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;

  logic [XLEN-1:0] regs_q [32];

  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic [4:0]      rd_q, rd_d;
  logic            valid_q, valid_d;
  logic [15:0]     count_q, count_d;

  logic            accept;
  logic            wb_hit;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [3:0]      ctrl_dec;

  assign in_ready = ~valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign wb_hit   = wb_en & (wb_rd != 5'd0);

  // Register file read ports; x0 is hard zero, same-cycle write-back wins.
  always_comb begin
    rs1_val = regs_q[in_rs1];
    rs2_val = regs_q[in_rs2];
    if (wb_hit && (wb_rd == in_rs1)) rs1_val = wb_data;
    if (wb_hit && (wb_rd == in_rs2)) rs2_val = wb_data;
    if (in_rs1 == 5'd0) rs1_val = '0;
    if (in_rs2 == 5'd0) rs2_val = '0;
  end

  // Decode the 2-bit operation into the ALU control encoding.
  always_comb begin
    ctrl_dec = CTRL_ADD;
    case (in_op)
      2'b00:   ctrl_dec = CTRL_ADD;
      2'b01:   ctrl_dec = CTRL_SUB;
      2'b10:   ctrl_dec = CTRL_AND;
      default: ctrl_dec = CTRL_OR;
    endcase
  end

  // Output slice next state: load on accept, otherwise hold; valid drops
  // only when the consumer takes the operands and nothing replaces them.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    rd_d    = rd_q;
    count_d = count_q;
    valid_d = valid_q & ~out_ready;
    if (accept) begin
      a_d     = rs1_val;
      b_d     = in_use_imm ? in_imm : rs2_val;
      ctrl_d  = ctrl_dec;
      rd_d    = in_rd;
      valid_d = 1'b1;
      count_d = count_q + 16'd1;
    end
  end

  // Register file write port; runs independently of any stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wb_hit) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  // Output register slice and accepted-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= CTRL_ADD;
      rd_q    <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign A           = a_q;
  assign B           = b_q;
  assign ALU_Control = ctrl_q;
  assign out_rd      = rd_q;
  assign out_valid   = valid_q;
  assign issue_count = count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with hand-computed expected values.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [1:0]  in_op;
  logic        in_use_imm;
  logic [63:0] in_imm;
  logic [63:0] A, B;
  logic [3:0]  ALU_Control;
  logic [4:0]  out_rd;
  logic        out_valid;
  logic        out_ready;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [15:0] issue_count;

  int checks = 0;
  int errors = 0;

  alu_issue_stage #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_op(in_op), .in_use_imm(in_use_imm), .in_imm(in_imm),
    .A(A), .B(B), .ALU_Control(ALU_Control), .out_rd(out_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .issue_count(issue_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [1:0] op, input logic use_imm, input logic [63:0] imm);
    in_valid   = 1'b1;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_rd      = rd;
    in_op      = op;
    in_use_imm = use_imm;
    in_imm     = imm;
  endtask

  task automatic drive_wb(input logic en, input logic [4:0] rd, input logic [63:0] data);
    wb_en   = en;
    wb_rd   = rd;
    wb_data = data;
  endtask

  task automatic check_out(input string tag, input logic [63:0] ea, input logic [63:0] eb,
                           input logic [3:0] ectrl, input logic [4:0] erd, input logic [15:0] ecnt);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_A"}, A, ea);
    check({tag, "_B"}, B, eb);
    check({tag, "_ctrl"}, 64'(ALU_Control), 64'(ectrl));
    check({tag, "_rd"}, 64'(out_rd), 64'(erd));
    check({tag, "_cnt"}, 64'(issue_count), 64'(ecnt));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive_issue(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 64'd0);
    in_valid  = 1'b0;
    drive_wb(1'b0, 5'd0, 64'd0);
    repeat (2) step();

    // reset values
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_A", A, 64'd0);
    check("rst_B", B, 64'd0);
    check("rst_ctrl", 64'(ALU_Control), 64'h2);
    check("rst_rd", 64'(out_rd), 64'd0);
    check("rst_cnt", 64'(issue_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // first accept on the first edge after reset release, AND op
    rst_n = 1'b1;
    drive_issue(5'd0, 5'd0, 5'd1, 2'b10, 1'b1, 64'h55);
    step();
    check_out("first", 64'd0, 64'h55, 4'b0000, 5'd1, 16'd1);

    // drain with no accept: valid clears; write x5, x6
    in_valid = 1'b0;
    drive_wb(1'b1, 5'd5, 64'h10);
    step();
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_A_kept", A, 64'd0);
    check("drain_B_kept", B, 64'h55);
    drive_wb(1'b1, 5'd6, 64'h3);
    step();
    drive_wb(1'b0, 5'd0, 64'd0);

    // SUB from registers
    drive_issue(5'd5, 5'd6, 5'd9, 2'b01, 1'b0, 64'd0);
    step();
    check_out("sub", 64'h10, 64'h3, 4'b0110, 5'd9, 16'd2);

    // same-cycle write-back bypass, back-to-back with previous
    drive_wb(1'b1, 5'd7, 64'hDEAD);
    drive_issue(5'd7, 5'd0, 5'd3, 2'b00, 1'b1, 64'h1);
    step();
    check_out("bypass", 64'hDEAD, 64'h1, 4'b0010, 5'd3, 16'd3);

    // x0 ignores writes and is not bypassed
    drive_wb(1'b1, 5'd0, 64'hFFFF);
    drive_issue(5'd0, 5'd0, 5'd2, 2'b11, 1'b0, 64'd0);
    step();
    check_out("x0_same", 64'd0, 64'd0, 4'b0001, 5'd2, 16'd4);
    drive_wb(1'b0, 5'd0, 64'd0);
    drive_issue(5'd0, 5'd7, 5'd2, 2'b11, 1'b0, 64'd0);
    step();
    check_out("x0_after", 64'd0, 64'hDEAD, 4'b0001, 5'd2, 16'd5);

    // stall for 3 cycles; write-back during stall must not touch held B
    out_ready = 1'b0;
    drive_issue(5'd5, 5'd6, 5'd4, 2'b10, 1'b0, 64'd0);
    drive_wb(1'b1, 5'd7, 64'hBEEF);
    #1;
    check("stall_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      drive_wb(1'b0, 5'd0, 64'd0);
      check_out($sformatf("stall%0d", i), 64'd0, 64'hDEAD, 4'b0001, 5'd2, 16'd5);
      check($sformatf("stall%0d_in_ready", i), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 64'(in_ready), 64'd1);
    step();
    check_out("release0", 64'h10, 64'h3, 4'b0000, 5'd4, 16'd6);
    drive_issue(5'd7, 5'd5, 5'd8, 2'b00, 1'b0, 64'd0);
    step();
    check_out("release1", 64'hBEEF, 64'h10, 4'b0010, 5'd8, 16'd7);

    // asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    drive_issue(5'd5, 5'd5, 5'd6, 2'b01, 1'b0, 64'd0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_cnt", 64'(issue_count), 64'd0);
    check("arst_A", A, 64'd0);
    check("arst_B", B, 64'd0);
    check("arst_ctrl", 64'(ALU_Control), 64'h2);
    check("arst_rd", 64'(out_rd), 64'd0);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive_issue(5'd7, 5'd5, 5'd2, 2'b01, 1'b0, 64'd0);
    step();
    check_out("post_rst", 64'd0, 64'd0, 4'b0110, 5'd2, 16'd1);

    // counter wrap after 65536 accepts from reset
    rst_n = 1'b0;
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    drive_issue(5'd0, 5'd0, 5'd1, 2'b11, 1'b1, 64'h77);
    repeat (65535) step();
    check("wrap_ffff", 64'(issue_count), 64'hFFFF);
    step();
    check_out("wrap", 64'd0, 64'h77, 4'b0001, 5'd1, 16'd0);

    in_valid = 1'b0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
